// File: rtl/fake_axi_ram_lat.sv
// AXI4 slave RAM model: first R beat RD_LATENCY cycles after AR, B response WR_LATENCY cycles after last W.
// R/B outputs hold until rready/bready; one burst in flight per direction, optional R bubble every R_STALL_EVERY beats.
module fake_axi_ram_lat #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 512,
    parameter int ID_WIDTH       = 6,
    parameter int MEM_WORDS_LOG2 = 16,
    parameter int RD_LATENCY     = 4,
    parameter int WR_LATENCY     = 2,
    parameter int R_STALL_EVERY  = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ID_WIDTH-1:0]       s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [7:0]                s_axi_awlen,
    input  logic [2:0]                s_axi_awsize,
    input  logic [1:0]                s_axi_awburst,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                      s_axi_wlast,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [ID_WIDTH-1:0]       s_axi_bid,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic [ID_WIDTH-1:0]       s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic [7:0]                s_axi_arlen,
    input  logic [2:0]                s_axi_arsize,
    input  logic [1:0]                s_axi_arburst,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [ID_WIDTH-1:0]       s_axi_rid,
    output logic [DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rlast,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
    localparam int IDX_TOP    = ADDR_LSB + MEM_WORDS_LOG2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [7:0] RD_WAIT_INIT = 8'(RD_LATENCY - 2);
    localparam logic [7:0] WR_WAIT_INIT = 8'(WR_LATENCY - 2);

    typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_BEAT, RD_STALL} rd_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_WAIT, WR_RESP} wr_state_t;

    logic [DATA_WIDTH-1:0] mem [2**MEM_WORDS_LOG2];

    // Low for one cycle after any reset edge so ready outputs stay quiet during reset.
    logic run;

    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >> IDX_TOP) != '0;
    endfunction

    always_ff @(posedge clk) run <= rst_n;

    rd_state_t                 rd_state, rd_next;
    logic [ID_WIDTH-1:0]       rd_id;
    logic [ADDR_WIDTH-1:0]     rd_addr;
    logic [7:0]                rd_len, rd_beat, rd_wait_cnt;
    logic [2:0]                rd_size;
    logic [1:0]                rd_burst;
    logic                      rd_err;
    logic [31:0]               rd_stall_cnt;
    logic                      ar_hs, rd_last, rd_stall_now;

    assign ar_hs        = s_axi_arvalid && s_axi_arready;
    assign rd_last      = rd_beat == rd_len;
    assign rd_stall_now = (R_STALL_EVERY > 0) && (rd_stall_cnt == 32'(R_STALL_EVERY - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) rd_state <= RD_IDLE;
        else        rd_state <= rd_next;
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE:  if (ar_hs) rd_next = (RD_LATENCY == 1) ? RD_BEAT : RD_WAIT;
            RD_WAIT:  if (rd_wait_cnt == '0) rd_next = RD_BEAT;
            RD_BEAT:  if (s_axi_rready) begin
                          if (rd_last)           rd_next = RD_IDLE;
                          else if (rd_stall_now) rd_next = RD_STALL;
                      end
            RD_STALL: rd_next = RD_BEAT;
            default:  rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_id <= '0; rd_addr <= '0; rd_len <= '0; rd_size <= '0; rd_burst <= '0;
            rd_err <= 1'b0; rd_beat <= '0; rd_wait_cnt <= '0; rd_stall_cnt <= '0;
        end else begin
            if (ar_hs) begin
                rd_id        <= s_axi_arid;
                rd_addr      <= s_axi_araddr;
                rd_len       <= s_axi_arlen;
                rd_size      <= s_axi_arsize;
                rd_burst     <= s_axi_arburst;
                rd_err       <= s_axi_arburst[1] || out_of_range(s_axi_araddr);
                rd_beat      <= '0;
                rd_wait_cnt  <= RD_WAIT_INIT;
                rd_stall_cnt <= '0;
            end
            if (rd_state == RD_WAIT) rd_wait_cnt <= rd_wait_cnt - 8'd1;
            if (rd_state == RD_BEAT && s_axi_rready && !rd_last) begin
                rd_beat      <= rd_beat + 8'd1;
                rd_stall_cnt <= rd_stall_now ? '0 : rd_stall_cnt + 32'd1;
                if (rd_burst == BURST_INCR) rd_addr <= rd_addr + (ADDR_ONE << rd_size);
            end
        end
    end

    always_comb begin
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        s_axi_rid     = '0;
        s_axi_rdata   = '0;
        s_axi_rresp   = RESP_OKAY;
        s_axi_rlast   = 1'b0;
        case (rd_state)
            RD_IDLE: s_axi_arready = run;
            RD_BEAT: begin
                s_axi_rvalid = 1'b1;
                s_axi_rid    = rd_id;
                s_axi_rdata  = rd_err ? '0 : mem[rd_addr[ADDR_LSB +: MEM_WORDS_LOG2]];
                s_axi_rresp  = rd_err ? RESP_SLVERR : RESP_OKAY;
                s_axi_rlast  = rd_last;
            end
            default: ;
        endcase
    end

    wr_state_t                 wr_state, wr_next;
    logic [ID_WIDTH-1:0]       wr_id;
    logic [ADDR_WIDTH-1:0]     wr_addr;
    logic [7:0]                wr_len, wr_wait_cnt;
    logic [8:0]                wr_beat;
    logic [2:0]                wr_size;
    logic [1:0]                wr_burst;
    logic                      wr_err, wr_bad, wr_bad_now;
    logic                      aw_hs, w_hs, wr_at_len, mem_we;

    assign aw_hs      = s_axi_awvalid && s_axi_awready;
    assign w_hs       = s_axi_wvalid && s_axi_wready;
    assign wr_at_len  = wr_beat == {1'b0, wr_len};
    // Early wlast, or no wlast on the final beat, poisons the response.
    assign wr_bad_now = wr_bad || (s_axi_wlast ? !wr_at_len : wr_at_len);
    assign mem_we     = rst_n && w_hs && !wr_err && (wr_beat <= {1'b0, wr_len});

    always_ff @(posedge clk) begin
        if (!rst_n) wr_state <= WR_IDLE;
        else        wr_state <= wr_next;
    end

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            WR_IDLE: if (aw_hs) wr_next = WR_DATA;
            WR_DATA: if (w_hs && s_axi_wlast) wr_next = (WR_LATENCY == 1) ? WR_RESP : WR_WAIT;
            WR_WAIT: if (wr_wait_cnt == '0) wr_next = WR_RESP;
            WR_RESP: if (s_axi_bready) wr_next = WR_IDLE;
            default: wr_next = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_id <= '0; wr_addr <= '0; wr_len <= '0; wr_size <= '0; wr_burst <= '0;
            wr_err <= 1'b0; wr_bad <= 1'b0; wr_beat <= '0; wr_wait_cnt <= '0;
        end else begin
            if (aw_hs) begin
                wr_id    <= s_axi_awid;
                wr_addr  <= s_axi_awaddr;
                wr_len   <= s_axi_awlen;
                wr_size  <= s_axi_awsize;
                wr_burst <= s_axi_awburst;
                wr_err   <= s_axi_awburst[1] || out_of_range(s_axi_awaddr);
                wr_bad   <= 1'b0;
                wr_beat  <= '0;
            end
            if (w_hs) begin
                wr_bad <= wr_bad_now;
                if (wr_beat != '1) wr_beat <= wr_beat + 9'd1;
                if (wr_burst == BURST_INCR) wr_addr <= wr_addr + (ADDR_ONE << wr_size);
                if (s_axi_wlast) wr_wait_cnt <= WR_WAIT_INIT;
            end
            if (wr_state == WR_WAIT) wr_wait_cnt <= wr_wait_cnt - 8'd1;
        end
    end

    always_comb begin
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_bid     = '0;
        s_axi_bresp   = RESP_OKAY;
        case (wr_state)
            WR_IDLE: s_axi_awready = run;
            WR_DATA: s_axi_wready  = 1'b1;
            WR_RESP: begin
                s_axi_bvalid = 1'b1;
                s_axi_bid    = wr_id;
                s_axi_bresp  = (wr_err || wr_bad) ? RESP_SLVERR : RESP_OKAY;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (s_axi_wstrb[b]) mem[wr_addr[ADDR_LSB +: MEM_WORDS_LOG2]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end
endmodule
